ahb_bram_ctrl: RTL and testbench

AHB-Lite slave that fronts the dual-port block RAM used as Cortex-M0 code/data memory. It converts pipelined AHB-Lite transfers into the RAM's byte-enabled write port (A) and registered read port (B). It also resolves the read-after-write hazard created by the RAM's one-cycle read latency. It sits between the system bus matrix and the RAM instance, one controller per RAM.

---
 rtl/ahb_bram_ctrl_if.sv | 24 ++
 rtl/ahb_bram_ctrl.sv | 159 +++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite signal bundle between the bus matrix (master side) and ahb_bram_ctrl (slave side).
// Handshake: a transfer is taken when HSEL & HTRANS[1] & HREADY; its data phase ends on the cycle HREADYOUT is high.
interface ahb_bram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port BRAM (byte-enabled write port A, registered read port B).
// Define AHB_BRAM_FWD_EN to forward write data on a read-after-write hazard instead of stalling.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_bram_ctrl_if.slave        ahb,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_RDATA  = 3'd2,
        ST_RSTALL = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;

    logic                  accept;
    logic                  illegal;
    logic                  hazard;
    logic [ADDR_WIDTH-1:0] haddr_idx;
    logic [3:0]            haddr_mask;

    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    // Address-phase decode: word index, little-endian byte mask, legality, hazard.
    always_comb begin
        haddr_idx = ahb.HADDR[ADDR_WIDTH+1:2];
        accept    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
        illegal   = (ahb.HSIZE > 3'd2)
                  | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
                  | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));
        case (ahb.HSIZE)
            3'd0:    haddr_mask = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    haddr_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: haddr_mask = 4'b1111;
        endcase
        hazard = accept & ~illegal & ~ahb.HWRITE
               & (state_q == ST_WDATA) & (haddr_idx == addr_q);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        case (state_q)
            ST_ERR1:   state_d = ST_ERR2;
            ST_RSTALL: state_d = ST_RDATA;
            default: begin
                // A low HREADY (another slave stretching its data phase) freezes everything.
                if (ahb.HREADY) begin
                    if (!accept) begin
                        state_d = ST_IDLE;
                    end else if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (ahb.HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
`ifdef AHB_BRAM_FWD_EN
                        state_d = ST_RDATA;
`else
                        state_d = hazard ? ST_RSTALL : ST_RDATA;
`endif
                    end
                    if (accept) begin
                        addr_d = haddr_idx;
                        mask_d = haddr_mask;
                    end
                end
            end
        endcase
    end

`ifdef AHB_BRAM_FWD_EN
    logic [31:0] fwd_data_q, fwd_data_d;
    logic [3:0]  fwd_mask_q, fwd_mask_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else begin
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
        end
    end

    // The write being committed this cycle is captured for the overlapping read only.
    always_comb begin
        fwd_data_d = fwd_data_q;
        fwd_mask_d = fwd_mask_q;
        if (ahb.HREADY) begin
            fwd_mask_d = hazard ? mask_q : 4'b0000;
            fwd_data_d = hazard ? ahb.HWDATA : fwd_data_q;
        end
    end
`endif

    always_comb begin
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = 1'b0;
        ahb.HRDATA    = '0;
        ram_wea       = 4'b0000;
        ram_addra     = addr_q;
        ram_dina      = ahb.HWDATA;
        ram_addrb     = haddr_idx;
        case (state_q)
            ST_WDATA: ram_wea = mask_q;
            ST_RDATA: begin
`ifdef AHB_BRAM_FWD_EN
                for (int i = 0; i < 4; i++) begin
                    ahb.HRDATA[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8]
                                                         : ram_doutb[8*i +: 8];
                end
`else
                ahb.HRDATA = ram_doutb;
`endif
            end
            ST_RSTALL: begin
                ahb.HREADYOUT = 1'b0;
                ram_addrb     = addr_q;
            end
            ST_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = 1'b1;
            end
            ST_ERR2: ahb.HRESP = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl: pipelined AHB driver, behavioural BRAM, reference memory model.
`timescale 1ns/1ps
module tb_ahb_bram_ctrl;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;
    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;
`ifdef AHB_BRAM_FWD_EN
    localparam int STALL_WAITS = 0;
`else
    localparam int STALL_WAITS = 1;
`endif

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] idx;
        logic [3:0]    mask;
        logic [31:0]   data;
        logic [1:0]    waits;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ext_rdy = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ahb_bram_ctrl_if bus();
    assign bus.HREADY = bus.HREADYOUT & ext_rdy;

    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_dina, ram_doutb;
    logic [3:0]    ram_wea;
    logic [2:0]    dbg_state;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .ahb       (bus),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb),
        .dbg_state (dbg_state)
    );

    // behavioural dual-port BRAM, read-first on a same-cycle collision
    logic [31:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        ram_doutb <= ram_mem[ram_addrb];
        for (int i = 0; i < 4; i++)
            if (ram_wea[i]) ram_mem[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    end

    // reference model and scoreboard
    logic [31:0] ref_mem [DEPTH];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          last_wr_cyc = -10;
    logic [AW-1:0] last_wr_idx = '0;
    bit          prev_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic wr, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   nb, lo;
        e = '0;
        e.idx = addr[AW+1:2];
        if (size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00)) begin
            e.kind  = K_ERR;
            e.waits = 2'd1;
        end else if (wr) begin
            nb = 1 << size;
            lo = int'(addr[1:0]);
            for (int k = 0; k < 4; k++)
                if (k >= lo && k < lo + nb) begin
                    e.mask[k] = 1'b1;
                    ref_mem[e.idx][8*k +: 8] = wdata[8*k +: 8];
                end
            e.kind      = K_WR;
            e.data      = wdata;
            last_wr_cyc = cyc;
            last_wr_idx = e.idx;
        end else begin
            e.kind  = K_RD;
            e.data  = ref_mem[e.idx];
            e.waits = (last_wr_cyc == cyc - 1 && last_wr_idx == e.idx) ? 2'(STALL_WAITS) : 2'd0;
        end
        exp_q.push_back(e);
    endtask

    // driver: present an address phase, wait for acceptance, then drive its write data
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
        bit got;
        int n;
        bit acc;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
        if (hold > 0) begin
            ext_rdy = 1'b0;
            repeat (hold) @(posedge clk);
            #1 ext_rdy = 1'b1;
        end
        got = 1'b0;
        n   = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            got = bus.HREADY;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL driver_timeout: HREADY low for %0d cycles, required high", n);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        acc = sel & trans[1];
        bus.HWDATA = (acc && wr) ? wdata : $urandom();
        if (acc) model_push(wr, size, addr, wdata);
        prev_acc = acc;
    endtask

    task automatic idle();
        xfer(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 0);
    endtask

    // monitor: follows data phases on the bus and pops one expectation per completion
    initial begin : monitor
        bit   dphase;
        int   waits;
        exp_t e;
        dphase = 1'b0;
        waits  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dphase = 1'b0;
                waits  = 0;
            end else begin
                if (dphase) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_dphase", 32'd1, 32'd0);
                        dphase = 1'b0;
                    end else begin
                        e = exp_q[0];
                        if (!bus.HREADYOUT) begin
                            waits++;
                            check("wait_hresp", 32'(bus.HRESP), 32'(e.kind == K_ERR));
                            check("wait_wea", 32'(ram_wea), 32'd0);
                        end else begin
                            void'(exp_q.pop_front());
                            check("wait_states", 32'(waits), 32'(e.waits));
                            case (e.kind)
                                K_WR: begin
                                    check("wr_hresp", 32'(bus.HRESP), 32'd0);
                                    check("wr_wea", 32'(ram_wea), 32'(e.mask));
                                    check("wr_addra", 32'(ram_addra), 32'(e.idx));
                                    check("wr_dina", ram_dina, e.data);
                                end
                                K_RD: begin
                                    check("rd_hresp", 32'(bus.HRESP), 32'd0);
                                    check("rd_hrdata", bus.HRDATA, e.data);
                                    check("rd_wea", 32'(ram_wea), 32'd0);
                                end
                                default: begin
                                    check("err_hresp", 32'(bus.HRESP), 32'd1);
                                    check("err_wea", 32'(ram_wea), 32'd0);
                                end
                            endcase
                            waits  = 0;
                            dphase = 1'b0;
                        end
                    end
                end else begin
                    check("idle_bus", 32'({bus.HREADYOUT, bus.HRESP, ram_wea}), 32'b100000);
                end
                if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) dphase = 1'b1;
            end
        end
    end

    // stimulus
    initial begin : stim
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.HSEL   = 1'b0;
        bus.HTRANS = T_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HADDR  = 32'h0;
        bus.HWDATA = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("reset_hresp", 32'(bus.HRESP), 32'd0);
        check("reset_wea", 32'(ram_wea), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word write, idle, read back
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
        idle();
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h100, 32'h0, 0);
        idle();

        // byte lanes then word read
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h200, 32'h11111111, 0);
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h201, 32'h22222222, 0);
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h202, 32'h33333333, 0);
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd0, 32'h203, 32'h44444444, 0);
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h200, 32'h0, 0);
        idle();

        // read-after-write hazard on the same word
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h300, 32'h00000000, 0);
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd1, 32'h302, 32'hABCDABCD, 0);
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h300, 32'h0, 0);
        idle();

        // misaligned word write -> ERROR, followed straight away by a read
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h101, 32'h55555555, 0);
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h100, 32'h0, 0);
        idle();

        // deselected / IDLE / BUSY cycles must not touch the RAM
        xfer(1'b0, T_NONSEQ, 1'b1, 3'd2, 32'h100, 32'h66666666, 0);
        xfer(1'b1, T_IDLE, 1'b1, 3'd2, 32'h100, 32'h77777777, 0);
        xfer(1'b1, T_BUSY, 1'b1, 3'd2, 32'h100, 32'h88888888, 0);
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h100, 32'h0, 3);
        idle();

        // reset during a write data phase
        xfer(1'b1, T_NONSEQ, 1'b1, 3'd2, 32'h400, 32'h12345678, 0);
        idle();
        bus.HSEL   = 1'b1;
        bus.HTRANS = T_NONSEQ;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = 3'd2;
        bus.HADDR  = 32'h400;
        @(posedge clk);
        #1;
        bus.HTRANS = T_IDLE;
        bus.HWDATA = 32'hCAFEF00D;
        check("pre_reset_wea", 32'(ram_wea), 32'hF);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_wea", 32'(ram_wea), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("post_reset_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        xfer(1'b1, T_NONSEQ, 1'b0, 3'd2, 32'h400, 32'h0, 0);
        idle();

        // randomized traffic over a few words to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic       sel, wr;
            logic [1:0] trans;
            logic [2:0] size;
            int         hold;
            sel   = ($urandom_range(0, 9) != 0);
            trans = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) trans[1] = 1'b1;
            wr    = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a     = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            hold  = (!prev_acc && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            xfer(sel, trans, wr, size, a, $urandom(), hold);
        end
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
